alu_exec_ctrl: RTL and testbench

- Execute-stage sequencer that sits directly upstream of the 4-bit ALU and also consumes its result.
- Accepts 8-bit instructions over a valid/ready handshake and reads two operands from an internal 4x4-bit register file.
- Drives the ALU operand and opcode inputs, captures the ALU output, writes it back to the register file and updates zero/negative flags.
- An external load port preloads registers; a debug port reads them.

---
 rtl/alu_exec_ctrl_pkg.sv | 35 +++
 rtl/alu_exec_ctrl_reg_file_4x4.sv | 51 +++++
 rtl/alu_exec_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_ctrl_pkg
// Description : Shared definitions for the ALU execute-stage sequencer.
//               Provides the ALU opcode constants, the sequencer state
//               encoding and the bit positions of the 8-bit instruction
//               fields.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_ctrl_pkg;

  // ALU opcodes carried in instr[7:6] and driven onto alu_op
  localparam logic [1:0] OP_ADD = 2'b00;  // X + Y (wraps)
  localparam logic [1:0] OP_SUB = 2'b01;  // X - Y (wraps)
  localparam logic [1:0] OP_AND = 2'b10;  // X & Y
  localparam logic [1:0] OP_NOT = 2'b11;  // ~X, Y ignored

  // Instruction layout: [7:6] op, [5:4] rd, [3:2] rs, [1:0] rt
  localparam int INSTR_W      = 8;
  localparam int OP_W         = 2;
  localparam int INSTR_OP_LSB = 6;
  localparam int INSTR_RD_LSB = 4;
  localparam int INSTR_RS_LSB = 2;
  localparam int INSTR_RT_LSB = 0;

  // Sequencer states: one instruction occupies READ, EXEC and WB in turn
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage : alu_exec_ctrl_pkg
`default_nettype wire

// File: rtl/alu_exec_ctrl_reg_file_4x4.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_4x4
// Description : Small register file, 2**AW entries of DATA_W bits.
//               Two asynchronous operand read ports, one asynchronous debug
//               read port, one synchronous write port, asynchronous
//               active-low clear of every entry.
// Ports       : clk, rst_n            - clock / async active-low clear
//               we_i, waddr_i, wdata_i - synchronous write port
//               raddr_a_i / rdata_a_o  - operand read port A
//               raddr_b_i / rdata_b_o  - operand read port B
//               raddr_dbg_i / rdata_dbg_o - debug read port
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_4x4 #(
  parameter int DATA_W = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [AW-1:0]     raddr_dbg_i,
  output logic [DATA_W-1:0] rdata_dbg_o
);

  localparam int DEPTH = 2 ** AW;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o   = mem_q[raddr_a_i];
  assign rdata_b_o   = mem_q[raddr_b_i];
  assign rdata_dbg_o = mem_q[raddr_dbg_i];

endmodule : reg_file_4x4
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_ctrl
// Description : Execute-stage sequencer wrapped around an external 4-bit
//               ALU. Accepts an instruction over valid/ready, reads two
//               operands from the internal register file, presents them to
//               the ALU, captures the ALU result, writes it back and updates
//               the zero/negative flags. Handshake at cycle 0, done pulse at
//               cycle 3, result visible on the debug port at cycle 4.
// Ports       : clk, rst_n                    - clock / async active-low reset
//               instr_valid, instr_ready, instr - instruction handshake
//               ld_en, ld_addr, ld_data      - register preload (IDLE only)
//               alu_x, alu_y, alu_op, alu_o  - ALU operand/opcode/result
//               done, flag_z, flag_n, busy   - status
//               dbg_addr, dbg_data           - combinational register read
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int REG_AW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               ld_en,
  input  logic [REG_AW-1:0]  ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  output logic [DATA_W-1:0]  alu_x,
  output logic [DATA_W-1:0]  alu_y,
  output logic [OP_W-1:0]    alu_op,
  input  logic [DATA_W-1:0]  alu_o,
  output logic               done,
  output logic               flag_z,
  output logic               flag_n,
  output logic               busy,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  state_e state_q, state_d;

  // Instruction fields captured at the handshake; instr is ignored afterwards
  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] rd_q, rs_q, rt_q;

  logic [DATA_W-1:0] alu_x_q, alu_y_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0] result_q;
  logic              flag_z_q, flag_n_q;

  logic              handshake;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rs_data, rt_data;

  // A preload in IDLE takes priority: ready drops so a pending instruction
  // waits one cycle and then sees the freshly loaded value.
  assign instr_ready = (state_q == ST_IDLE) && !ld_en;
  assign handshake   = instr_valid && instr_ready;
  assign busy        = (state_q != ST_IDLE);

  // Next-state and done decode
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (handshake) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      alu_x_q  <= '0;
      alu_y_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      if (handshake) begin
        op_q <= instr[INSTR_OP_LSB +: OP_W];
        rd_q <= instr[INSTR_RD_LSB +: REG_AW];
        rs_q <= instr[INSTR_RS_LSB +: REG_AW];
        rt_q <= instr[INSTR_RT_LSB +: REG_AW];
      end
      // Operands are latched here, so a write-back to rs/rt is harmless
      if (state_q == ST_READ) begin
        alu_x_q  <= rs_data;
        alu_y_q  <= rt_data;
        alu_op_q <= op_q;
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_o;
      end
      if (state_q == ST_WB) begin
        flag_z_q <= (result_q == '0);
        flag_n_q <= result_q[DATA_W-1];
      end
    end
  end

  // Write mux: write-back in WB, preload only in IDLE, otherwise no write
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (state_q == ST_WB) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = result_q;
    end else if (state_q == ST_IDLE && ld_en) begin
      rf_we = 1'b1;
    end
  end

  reg_file_4x4 #(
    .DATA_W (DATA_W),
    .AW     (REG_AW)
  ) u_reg_file (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_i        (rf_we),
    .waddr_i     (rf_waddr),
    .wdata_i     (rf_wdata),
    .raddr_a_i   (rs_q),
    .rdata_a_o   (rs_data),
    .raddr_b_i   (rt_q),
    .rdata_b_o   (rt_data),
    .raddr_dbg_i (dbg_addr),
    .rdata_dbg_o (dbg_data)
  );

  assign alu_x  = alu_x_q;
  assign alu_y  = alu_y_q;
  assign alu_op = alu_op_q;
  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;

endmodule : alu_exec_ctrl
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_exec_ctrl
// Description : Self-checking bench for alu_exec_ctrl with a behavioural ALU
//               attached and a register/flag reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [3:0] alu_x, alu_y, alu_o;
  logic [1:0] alu_op;
  logic       done, flag_z, flag_n, busy;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_hs = -100;

  // reference state
  int m_reg [4];
  int m_z, m_n;

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  // combinational ALU that the block drives
  always_comb begin
    alu_o = 4'h0;
    case (alu_op)
      2'b00: alu_o = alu_x + alu_y;
      2'b01: alu_o = alu_x - alu_y;
      2'b10: alu_o = alu_x & alu_y;
      2'b11: alu_o = ~alu_x;
      default: alu_o = 4'h0;
    endcase
  end

  alu_exec_ctrl #(.DATA_W(4), .REG_AW(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_op      (alu_op),
    .alu_o       (alu_o),
    .done        (done),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .busy        (busy),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_alu(input int op, input int x, input int y);
    case (op)
      0: return (x + y) % 16;
      1: return (x - y + 16) % 16;
      2: return x & y;
      default: return 15 - x;
    endcase
  endfunction

  task automatic read_reg(input int a, output int v);
    dbg_addr = a[1:0];
    #1;
    v = int'(dbg_data);
  endtask

  // all four registers plus flags against the model
  task automatic check_state(input string tag);
    int v;
    for (int a = 0; a < 4; a++) begin
      read_reg(a, v);
      chk($sformatf("%s_r%0d", tag, a), v, m_reg[a]);
    end
    chk({tag, "_z"}, int'(flag_z), m_z);
    chk({tag, "_n"}, int'(flag_n), m_n);
  endtask

  // called at a negedge while idle; returns at the next negedge
  task automatic do_load(input int a, input int d);
    ld_en = 1'b1; ld_addr = a[1:0]; ld_data = d[3:0];
    @(negedge clk);
    ld_en = 1'b0;
    m_reg[a] = d;
  endtask

  // Issue one instruction starting at a negedge; returns at the negedge of
  // cycle 4 (block idle again). With hold set, instr_valid stays high
  // carrying next_ins so the following send sees a back-to-back request.
  task automatic send(input logic [7:0] ins, input bit chained,
                      input bit hold, input logic [7:0] next_ins);
    int op, rd, rs, rt, xs, ys, res, n;
    bit ok;
    instr_valid = 1'b1;
    instr       = ins;
    ok = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (instr_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("hs_timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    if (chained) chk("b2b_gap", cyc - last_hs, 4);
    last_hs = cyc;
    op = ins[7:6]; rd = ins[5:4]; rs = ins[3:2]; rt = ins[1:0];
    xs = m_reg[rs]; ys = m_reg[rt];
    res = ref_alu(op, xs, ys);
    @(negedge clk);
    if (hold) instr = next_ins;
    else begin
      instr_valid = 1'b0;
      instr = 8'($urandom);
    end
    n = 1;
    while (n < 8) begin
      #1;
      if (done) break;
      chk("busy", int'(busy), 1);
      chk("ready_busy", int'(instr_ready), 0);
      if (n == 2) begin
        chk("alu_x", int'(alu_x), xs);
        chk("alu_y", int'(alu_y), ys);
        chk("alu_op", int'(alu_op), op);
      end
      // loads outside IDLE must be ignored
      ld_en   = 1'($urandom);
      ld_addr = 2'($urandom);
      ld_data = 4'($urandom);
      @(negedge clk);
      n++;
    end
    ld_en = 1'b0;
    chk("latency", n, 3);
    m_reg[rd] = res;
    m_z = (res == 0);
    m_n = (res >= 8);
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
    chk("ready_idle", int'(instr_ready), 1);
    check_state("wb");
  endtask

  // instruction offered together with a preload of one of its sources
  task automatic send_with_load(input logic [7:0] ins, input int a, input int d);
    instr_valid = 1'b1; instr = ins;
    ld_en = 1'b1; ld_addr = a[1:0]; ld_data = d[3:0];
    #1;
    chk("ready_ld", int'(instr_ready), 0);
    @(negedge clk);
    ld_en = 1'b0;
    m_reg[a] = d;
    send(ins, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) m_reg[a] = 0;
    m_z = 0; m_n = 0;
  endtask

  int v;

  initial begin
    instr_valid = 1'b0; instr = 8'h00; ld_en = 1'b0;
    ld_addr = 2'd0; ld_data = 4'd0; dbg_addr = 2'd0;
    apply_reset();
    repeat (3) @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_alu_x", int'(alu_x), 0);
    chk("rst_alu_y", int'(alu_y), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    check_state("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(instr_ready), 1);

    // directed sequence
    do_load(1, 5);
    do_load(2, 3);
    send(8'h06, 1'b0, 1'b0, 8'h00);
    read_reg(0, v); chk("tp_add_r0", v, 8);
    chk("tp_add_n", int'(flag_n), 1);
    send(8'h79, 1'b0, 1'b0, 8'h00);
    read_reg(3, v); chk("tp_sub_r3", v, 14);
    send(8'h86, 1'b0, 1'b0, 8'h00);
    read_reg(0, v); chk("tp_and_r0", v, 1);
    chk("tp_and_n", int'(flag_n), 0);
    send(8'hD4, 1'b0, 1'b0, 8'h00);
    read_reg(1, v); chk("tp_not_r1", v, 10);
    do_load(1, 9);
    do_load(2, 7);
    send(8'h36, 1'b0, 1'b0, 8'h00);
    read_reg(3, v); chk("tp_wrap_r3", v, 0);
    chk("tp_wrap_z", int'(flag_z), 1);

    // load wins over a simultaneous instruction
    send_with_load(8'h06, 1, 4);
    read_reg(0, v); chk("tp_ldwin_r0", v, 11);

    // back-to-back: valid held through busy
    send(8'h1B, 1'b0, 1'b1, 8'h64);
    send(8'h64, 1'b1, 1'b1, 8'hE0);
    send(8'hE0, 1'b1, 1'b0, 8'h00);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [7:0] ins;
      ins = 8'($urandom);
      if ($urandom_range(0, 2) == 0)
        do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0)
        send_with_load(ins, int'(ins[3:2]), int'($urandom_range(0, 15)));
      else if ($urandom_range(0, 3) == 0) begin
        logic [7:0] nx;
        nx = 8'($urandom);
        send(ins, 1'b0, 1'b1, nx);
        send(nx, 1'b1, 1'b0, 8'h00);
      end else
        send(ins, 1'b0, 1'b0, 8'h00);
    end

    // reset in the middle of an instruction
    do_load(2, 6);
    instr_valid = 1'b1; instr = 8'h2A;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);             // EXEC
    apply_reset();
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_alu_x", int'(alu_x), 0);
    chk("mid_rst_alu_y", int'(alu_y), 0);
    chk("mid_rst_alu_op", int'(alu_op), 0);
    check_state("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_done", int'(done), 0);
      chk("post_rst_ready", int'(instr_ready), 1);
    end
    check_state("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu_exec_ctrl
`default_nettype wire
